// File: rtl/vga_pixel_prefetch_pkg.sv
// rtl/vga_pixel_prefetch_pkg.sv - shared types and constants for the VGA pixel prefetch stage
package vga_pixel_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    localparam int H_ACTIVE        = 640;
    localparam int V_ACTIVE        = 480;
    localparam int FRAME_WORDS_VGA = H_ACTIVE * V_ACTIVE;
    localparam int INDEX_W         = 19;

    localparam logic [15:0] UNDERFLOW_COLOR = 16'hF800;

    // Word address of a frame index; the 24-bit sum wraps at the top of DDR.
    function automatic logic [23:0] frame_addr(input logic [23:0] base, input logic [INDEX_W-1:0] index);
        return base + {{(24-INDEX_W){1'b0}}, index};
    endfunction

endpackage

// File: rtl/vga_pixel_prefetch_pixel_fifo.sv
// rtl/vga_pixel_prefetch_pixel_fifo.sv - single-clock pixel FIFO with registered read data
module vga_pixel_prefetch_pixel_fifo #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full
);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_rd;
    logic          do_wr;

    // A read of an empty FIFO is a no-op, so a same-cycle write into an empty FIFO is kept.
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(2**AW));
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                rdata  <= mem[rd_ptr];
            end
            level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/vga_pixel_prefetch.sv
// rtl/vga_pixel_prefetch.sv - DDR frame buffer prefetcher feeding VGA scan-out
module vga_pixel_prefetch
    import vga_pixel_prefetch_pkg::*;
#(
    parameter logic [23:0] FRAME_BASE  = 24'h000000,
    parameter int          FRAME_WORDS = FRAME_WORDS_VGA,
    parameter int          FIFO_AW     = 4,
    parameter int          TIMEOUT     = 63
) (
    input  logic               clk133_p,
    input  logic               rst,
    input  logic               frameStart,
    output logic               readRequest,
    output logic [23:0]        readAddress,
    input  logic               readValid,
    input  logic [15:0]        readData,
    input  logic               pixelRead,
    output logic [15:0]        pixelData,
    output logic [FIFO_AW:0]   fifoLevel,
    output logic               underflow,
    output logic               frameDone
);

    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(FRAME_WORDS);
    localparam logic [7:0]         TO_LIMIT   = 8'(TIMEOUT);

    fetch_state_t       state;
    logic [INDEX_W-1:0] index;
    logic [7:0]         tcnt;
    logic               fifo_wr;
    logic               fifo_rd;
    logic               fifo_empty;
    logic               fifo_full;
    logic [15:0]        fifo_rdata;
    logic               pix_uf;

    // frameStart wins over any same-cycle write or read.
    assign fifo_wr   = (state == ST_WAIT) && readValid && !frameStart;
    assign fifo_rd   = pixelRead && !frameStart;
    assign pixelData = pix_uf ? UNDERFLOW_COLOR : fifo_rdata;

    vga_pixel_prefetch_pixel_fifo #(
        .DW (16),
        .AW (FIFO_AW)
    ) u_pixel_fifo (
        .clk   (clk133_p),
        .rst   (rst),
        .flush (frameStart),
        .wr    (fifo_wr),
        .wdata (readData),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .level (fifoLevel),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Fetch FSM: one outstanding single-word read, reissued on timeout.
    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            index       <= '0;
            tcnt        <= '0;
            readRequest <= 1'b0;
            readAddress <= FRAME_BASE;
            frameDone   <= 1'b1;
        end else begin
            readRequest <= 1'b0;
            if (frameStart) begin
                index     <= '0;
                frameDone <= 1'b0;
                case (state)
                    ST_IDLE:    state <= ST_IDLE;
                    // The request pulse is already out, so its reply must be dropped.
                    ST_REQ: begin
                        tcnt  <= '0;
                        state <= ST_DISCARD;
                    end
                    default:    state <= ST_DISCARD;
                endcase
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!frameDone && !fifo_full) begin
                            state       <= ST_REQ;
                            readRequest <= 1'b1;
                            readAddress <= frame_addr(FRAME_BASE, index);
                        end
                    end
                    ST_REQ: begin
                        tcnt  <= '0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (readValid) begin
                            index <= index + 1'b1;
                            if (index + 1'b1 == LAST_INDEX) begin
                                frameDone <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end else if (tcnt + 8'd1 == TO_LIMIT) begin
                            state       <= ST_REQ;
                            readRequest <= 1'b1;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                    default: begin
                        if (readValid || (tcnt + 8'd1 == TO_LIMIT)) begin
                            state <= ST_IDLE;
                        end else begin
                            tcnt <= tcnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Sticky underflow flag and the per-read source select for pixelData.
    always_ff @(posedge clk133_p or posedge rst) begin
        if (rst) begin
            underflow <= 1'b0;
            pix_uf    <= 1'b0;
        end else if (frameStart) begin
            underflow <= 1'b0;
        end else if (pixelRead) begin
            if (fifo_empty) begin
                underflow <= 1'b1;
                pix_uf    <= 1'b1;
            end else begin
                pix_uf <= 1'b0;
            end
        end
    end

endmodule
